// File: rtl/core_pkg.sv
// core_pkg: shared encodings for the RV32I memory stage.
package core_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
   typedef enum logic [1:0] {IDLE, WAIT_G, WAIT_R} mem_state_e;
endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte-lane enables, store shift, misalign detect, load extract/extend.
module load_store_align
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_sh,
   output logic            misaligned,
   output logic [XLEN-1:0] rdata_ext
);
   logic [XLEN-1:0] rsh;
   assign misaligned = (funct3[1:0] == F3_H[1:0] && off[0]) || (funct3[1:0] == F3_W[1:0] && off != 2'b00);
   assign be = funct3[1:0] == F3_B[1:0] ? 4'b0001 << off :
               funct3[1:0] == F3_H[1:0] ? 4'b0011 << off : 4'b1111;
   assign wdata_sh = wdata << {off, 3'b000};
   assign rsh = rdata >> {off, 3'b000};
   assign rdata_ext = funct3 == F3_B  ? {{(XLEN-8){rsh[7]}}, rsh[7:0]} :
                      funct3 == F3_H  ? {{(XLEN-16){rsh[15]}}, rsh[15:0]} :
                      funct3 == F3_BU ? {{(XLEN-8){1'b0}}, rsh[7:0]} :
                      funct3 == F3_HU ? {{(XLEN-16){1'b0}}, rsh[15:0]} : rsh;
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: RV32I MEM stage with req/gnt/rvalid data-memory handshake
// and the MEM/WB pipeline register.
module memory_access_stage
   import core_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic [1:0]      ResultSrcM,
   input  logic [2:0]      funct3M,
   input  logic [4:0]      RdM,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [XLEN-1:0] PCPlus4M,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            StallM,
   output logic            ExcM,
   output logic            RegWriteW,
   output logic [1:0]      ResultSrcW,
   output logic [4:0]      RdW,
   output logic [XLEN-1:0] ALUResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic [XLEN-1:0] PCPlus4W
);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   mem_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            regwrite_q, regwrite_d;
   logic [1:0]      resultsrc_q, resultsrc_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] alu_q, alu_d, rdat_q, rdat_d, pc4_q, pc4_d, load_data;
   logic            is_load, is_mem, misaligned, timeout, req, gnt_hit, rv_hit, done, stall, exc, keep;
   assign is_load = ResultSrcM == RESULT_SRC_MEM;
   assign is_mem  = MemWriteM | is_load;
   load_store_align #(.XLEN(XLEN)) u_align (
      .funct3    (funct3M),
      .off       (ALUResultM[1:0]),
      .wdata     (WriteDataM),
      .rdata     (dmem_rdata),
      .be        (dmem_be),
      .wdata_sh  (dmem_wdata),
      .misaligned(misaligned),
      .rdata_ext (load_data)
   );
   // Timeout outranks a same-cycle gnt/rvalid: req is already dropped that cycle.
   assign timeout = TIMEOUT != 0 && state_q != IDLE && cnt_q == CW'(TIMEOUT);
   assign req     = state_q == IDLE ? is_mem & ~misaligned : state_q == WAIT_G && !timeout;
   assign gnt_hit = req & dmem_gnt;
   assign rv_hit  = state_q == WAIT_R && dmem_rvalid && !timeout;
   assign done    = gnt_hit & MemWriteM | rv_hit;
   assign stall   = (req | (state_q == WAIT_R && !timeout)) & ~done;
   assign exc     = (state_q == IDLE && is_mem && misaligned) | timeout;
   assign dmem_req  = req & rst_n;
   assign dmem_we   = req & MemWriteM & rst_n;
   assign dmem_addr = {ALUResultM[XLEN-1:2], 2'b00};
   assign StallM    = stall & rst_n;
   assign ExcM      = exc & rst_n;
   always_comb begin
      state_d     = timeout || done ? IDLE : gnt_hit ? WAIT_R : req ? WAIT_G : state_q;
      cnt_d       = state_q != IDLE && state_d != IDLE ? cnt_q + CW'(1) : '0;
      keep        = ~stall & ~exc;
      regwrite_d  = keep & RegWriteM;
      resultsrc_d = keep ? ResultSrcM : '0;
      rd_d        = keep ? RdM : '0;
      alu_d       = keep ? ALUResultM : '0;
      rdat_d      = keep && is_load ? load_data : '0;
      pc4_d       = keep ? PCPlus4M : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         regwrite_q  <= 1'b0;
         resultsrc_q <= '0;
         rd_q        <= '0;
         alu_q       <= '0;
         rdat_q      <= '0;
         pc4_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         regwrite_q  <= regwrite_d;
         resultsrc_q <= resultsrc_d;
         rd_q        <= rd_d;
         alu_q       <= alu_d;
         rdat_q      <= rdat_d;
         pc4_q       <= pc4_d;
      end
   end
   assign RegWriteW  = regwrite_q;
   assign ResultSrcW = resultsrc_q;
   assign RdW        = rd_q;
   assign ALUResultW = alu_q;
   assign ReadDataW  = rdat_q;
   assign PCPlus4W   = pc4_q;
endmodule
